// File: rtl/imem_responder_if.sv
// Fetch-side bus between the core's fetch stage (master) and the instruction
// memory responder (slave): request channel, response channel and redirect flush.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_inst;
  logic        resp_err;
  logic        flush;

  modport master (
    output req_valid, req_addr, resp_ready, flush,
    input  req_ready, resp_valid, resp_inst, resp_err
  );

  modport slave (
    input  req_valid, req_addr, resp_ready, flush,
    output req_ready, resp_valid, resp_inst, resp_err
  );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder. Fetch requests travel down a short pipeline,
// the store is read in the final stage and the word lands in an in-order
// response FIFO. A credit counter (pipeline + FIFO occupancy) bounds the number
// of requests in flight so the FIFO can never overflow. Flush drops everything
// in flight except a request accepted in the flush cycle itself.
module imem_responder #(
  parameter int unsigned WORDS       = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  imem_responder_if.slave          bus,
  input  logic                     load_en_i,
  input  logic [$clog2(WORDS)-1:0] load_idx_i,
  input  logic [31:0]              load_data_i
);
  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned PW = $clog2(OUTSTANDING);
  localparam int unsigned CW = $clog2(OUTSTANDING + 1);

  logic [31:0]      mem [WORDS];
  logic [31:0]      fifo_inst_q [OUTSTANDING];
  logic [OUTSTANDING-1:0] fifo_err_q;
  logic [PW-1:0]    wptr_q, rptr_q, wr_idx;
  logic [CW-1:0]    fcnt_q, cnt_q;

  logic             accept, pop, push, resp_valid;
  logic             rd_valid, fault;
  logic [63:0]      rd_addr, off, idx64;
  logic [31:0]      rd_word;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // req_ready depends only on the registered credit count, never on resp_ready
  assign bus.req_ready = !rst && (cnt_q < CW'(OUTSTANDING));
  assign accept        = bus.req_valid & bus.req_ready;
  assign resp_valid    = !rst && (fcnt_q != '0);
  assign pop           = resp_valid & bus.resp_ready & !bus.flush;

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [LATENCY-2:0] pv_q;
      logic [63:0]        pa_q [LATENCY-1];

      // Advance valid bits; flush kills older entries but keeps this cycle's accept
      always_ff @(posedge clk) begin
        if (rst) begin
          pv_q <= '0;
        end else begin
          pv_q[0] <= accept;
          for (int i = 1; i < LATENCY - 1; i++) pv_q[i] <= bus.flush ? 1'b0 : pv_q[i-1];
        end
      end

      // Address shift register travels alongside the valid bits
      always_ff @(posedge clk) begin
        pa_q[0] <= bus.req_addr;
        for (int i = 1; i < LATENCY - 1; i++) pa_q[i] <= pa_q[i-1];
      end

      assign rd_valid = pv_q[LATENCY-2];
      assign rd_addr  = pa_q[LATENCY-2];
    end else begin : g_nopipe
      assign rd_valid = accept;
      assign rd_addr  = bus.req_addr;
    end
  endgenerate

  // With a single-cycle latency the read stage is the accept itself, which survives flush
  assign push = rd_valid & ((LATENCY == 1) || !bus.flush);

  assign off     = rd_addr - BASE_ADDR;
  assign idx64   = off >> 2;
  assign fault   = (rd_addr[1:0] != 2'b00) || (rd_addr < BASE_ADDR) || (idx64 >= 64'(WORDS));
  assign rd_word = fault ? 32'h0 : mem[idx64[IW-1:0]];
  assign wr_idx  = bus.flush ? '0 : wptr_q;

  // Backdoor store write; a same-edge read in the final stage still sees the old word
  always_ff @(posedge clk) begin
    if (load_en_i) mem[load_idx_i] <= load_data_i;
  end

  // FIFO payload; contents need no reset because outputs are gated by resp_valid
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst_q[wr_idx] <= rd_word;
      fifo_err_q[wr_idx]  <= fault;
    end
  end

  // Pointers, FIFO occupancy and credit count
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else if (bus.flush) begin
      rptr_q <= '0;
      wptr_q <= push ? PW'(1) : '0;
      fcnt_q <= CW'(push);
      cnt_q  <= CW'(accept);
    end else begin
      if (push) wptr_q <= ptr_inc(wptr_q);
      if (pop)  rptr_q <= ptr_inc(rptr_q);
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      cnt_q  <= cnt_q + CW'(accept) - CW'(pop);
    end
  end

  assign bus.resp_valid = resp_valid;
  assign bus.resp_inst  = resp_valid ? fifo_inst_q[rptr_q] : 32'h0;
  assign bus.resp_err   = resp_valid & fifo_err_q[rptr_q];
endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a negedge monitor keeps an in-order scoreboard of
// expected responses (pushed on accept, popped on consume); scenario tasks add
// timing and handshake checks of their own.
module tb_imem_responder;
  localparam logic [63:0] BASE = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en_i = 1'b0;
  logic [9:0]  load_idx_i = '0;
  logic [31:0] load_data_i = '0;
  logic [31:0] model_mem [1024];
  logic [32:0] sb [$];
  int          total = 0;
  int          bad = 0;

  imem_responder_if bus ();

  imem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .load_en_i  (load_en_i),
    .load_idx_i (load_idx_i),
    .load_data_i(load_data_i)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] expect_of(input logic [63:0] a);
    logic [63:0] w;
    w = (a - BASE) >> 2;
    if (a[1:0] != 2'b00 || a < BASE || w >= 64'd1024) return {1'b1, 32'h0};
    return {1'b0, model_mem[w[9:0]]};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      sb.delete();
    end else begin
      if (bus.flush) begin
        sb.delete();
      end else if (bus.resp_valid && bus.resp_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_stale got err=%b inst=%h expected no response", bus.resp_err, bus.resp_inst);
        end else begin
          e = sb.pop_front();
          if ({bus.resp_err, bus.resp_inst} !== e) begin
            bad++;
            $display("FAIL sb_data got err=%b inst=%h expected err=%b inst=%h", bus.resp_err, bus.resp_inst, e[32], e[31:0]);
          end
        end
      end
      if (bus.req_valid && bus.req_ready) sb.push_back(expect_of(bus.req_addr));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b0 || bus.resp_inst !== 32'h0 || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got rdy=%b vld=%b inst=%h err=%b expected 0 0 0 0", bus.req_ready, bus.resp_valid, bus.resp_inst, bus.resp_err);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready_after got %b expected 1", bus.req_ready);
    end
  endtask

  task automatic load_store();
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = (i == 0) ? 32'h0000_0513 : (i == 1) ? 32'h0015_0513 : $urandom;
      model_mem[i] = w;
      @(posedge clk); #1;
      load_en_i = 1'b1; load_idx_i = 10'(i); load_data_i = w;
    end
    @(posedge clk); #1; load_en_i = 1'b0;
  endtask

  task automatic test_single();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = BASE;
    @(negedge clk);
    @(posedge clk); #1; bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_early got resp_valid=%b expected 0", bus.resp_valid);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_inst !== 32'h0000_0513 || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL single_resp got vld=%b inst=%h err=%b expected 1 00000513 0", bus.resp_valid, bus.resp_inst, bus.resp_err);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL single_idle got rdy=%b vld=%b expected 1 0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    bus.resp_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = BASE + 64'(acc * 4);
      @(negedge clk);
      if (bus.req_ready) acc++;
    end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    total++;
    if (acc != 4) begin
      bad++; $display("FAIL b2b_accepted got %0d expected 4", acc);
    end
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b0 || bus.resp_valid !== 1'b1 || bus.resp_inst !== model_mem[0]) begin
      bad++;
      $display("FAIL b2b_full got rdy=%b vld=%b inst=%h expected 0 1 %h", bus.req_ready, bus.resp_valid, bus.resp_inst, model_mem[0]);
    end
    @(negedge clk);
    total++;
    if (bus.resp_inst !== model_mem[0]) begin
      bad++; $display("FAIL b2b_hold got inst=%h expected %h", bus.resp_inst, model_mem[0]);
    end
    @(posedge clk); #1; bus.resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_inst !== model_mem[k]) begin
        bad++;
        $display("FAIL b2b_order%0d got vld=%b inst=%h expected 1 %h", k, bus.resp_valid, bus.resp_inst, model_mem[k]);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_drained got vld=%b rdy=%b expected 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_fault();
    logic [63:0] addrs [3];
    int errs = 0;
    addrs[0] = 64'h8000_0002; addrs[1] = 64'h7FFF_FFFC; addrs[2] = 64'h8000_1000;
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = addrs[i];
      @(negedge clk);
      if (bus.resp_valid) errs++;
    end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        errs++;
        total++;
        if (bus.resp_err !== 1'b1 || bus.resp_inst !== 32'h0) begin
          bad++; $display("FAIL fault_resp got err=%b inst=%h expected 1 00000000", bus.resp_err, bus.resp_inst);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (errs != 3) begin
      bad++; $display("FAIL fault_count got %0d expected 3", errs);
    end
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL fault_idle got rdy=%b vld=%b expected 1 0", bus.req_ready, bus.resp_valid);
    end
  endtask

  task automatic test_flush();
    int seen = 0;
    bus.resp_ready = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = BASE + 64'(i * 4);
    end
    @(posedge clk); #1;
    bus.flush = 1'b1; bus.resp_ready = 1'b1; bus.req_addr = BASE + 64'h4;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ready got %b expected 1", bus.req_ready);
    end
    @(posedge clk); #1; bus.flush = 1'b0; bus.req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0) begin
      bad++; $display("FAIL flush_early got vld=%b expected 0", bus.resp_valid);
    end
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b1 || bus.resp_inst !== model_mem[1] || bus.resp_err !== 1'b0) begin
      bad++;
      $display("FAIL flush_new got vld=%b inst=%h err=%b expected 1 %h 0", bus.resp_valid, bus.resp_inst, bus.resp_err, model_mem[1]);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL flush_old got %0d late responses expected 0", seen);
    end
  endtask

  task automatic test_full_wrap();
    int nxt = 9;
    bus.resp_ready = 1'b0;
    for (int i = 5; i < 9; i++) begin
      @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = BASE + 64'(i * 4);
    end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1;
      bus.resp_ready = 1'b1; bus.req_valid = 1'b1; bus.req_addr = BASE + 64'(nxt * 4);
      @(negedge clk);
      total++;
      if (c == 0) begin
        if (bus.req_ready !== 1'b0) begin
          bad++; $display("FAIL wrap_full got rdy=%b expected 0", bus.req_ready);
        end
      end else if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b1) begin
        bad++; $display("FAIL wrap_steady%0d got rdy=%b vld=%b expected 1 1", c, bus.req_ready, bus.resp_valid);
      end
      if (bus.req_ready) nxt++;
    end
    @(posedge clk); #1; bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || sb.size() != 0 || nxt != 19) begin
      bad++; $display("FAIL wrap_drain got vld=%b pending=%0d issued_to=%0d expected 0 0 19", bus.resp_valid, sb.size(), nxt);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    bus.resp_ready = 1'b0;
    for (int i = 2; i < 5; i++) begin
      @(posedge clk); #1; bus.req_valid = 1'b1; bus.req_addr = BASE + 64'(i * 4);
    end
    @(posedge clk); #1; bus.req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got vld=%b rdy=%b expected 0 0", bus.resp_valid, bus.req_ready);
    end
    @(posedge clk); #1; rst = 1'b0; bus.resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.resp_valid) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midrst_stale got %0d responses expected 0", seen);
    end
    test_single();
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.resp_ready = 1'b0; bus.flush = 1'b0;
    test_reset();
    load_store();
    test_single();
    test_back_to_back();
    test_fault();
    test_flush();
    test_full_wrap();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
